// File: rtl/i_fetch_stage.sv
// i_fetch_stage: IF stage of the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID pipeline register. It fetches through a
// req/ready instruction-memory handshake, honours the hazard unit's
// PCWrite/IFIDWrite stalls and redirects on taken branches and jumps
// resolved in ID, flushing the wrong-path slot.
module i_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        branchTaken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] npc_out,
    output logic        ifid_valid
);

    // FETCH: request outstanding at pc.
    // HOLD:  word already returned but the pipeline is stalled; it waits in the buffer.
    // DRAIN: a redirect arrived while a request was outstanding; the memory
    //        must still complete it, and its data is thrown away.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] npc;

    logic        run;

    logic [31:0] saved_target;
    logic [31:0] saved_target_next;

    logic [31:0] hold_instr;
    logic [31:0] hold_instr_next;
    logic [31:0] hold_npc;
    logic [31:0] hold_npc_next;

    logic [31:0] ifid_instr_next;
    logic [31:0] ifid_npc_next;
    logic        ifid_valid_next;

    logic        redir;
    logic [31:0] redir_target;
    logic        advance;

    // PC+4 wraps naturally modulo 2^32.
    assign npc          = pc + 32'd4;
    assign imem_addr    = pc;

    // A redirect only counts when the PC is allowed to move; jump outranks branch.
    assign redir        = (branchTaken | jump) & PCWrite;
    assign redir_target = jump ? jump_target : branch_target;
    assign advance      = PCWrite & IFIDWrite;

    // Next-state, next-PC, buffer and IF/ID update selection.
    always_comb begin
        state_next        = state;
        pc_next           = pc;
        saved_target_next = saved_target;
        hold_instr_next   = hold_instr;
        hold_npc_next     = hold_npc;
        ifid_instr_next   = instruction_out;
        ifid_npc_next     = npc_out;
        ifid_valid_next   = ifid_valid;
        imem_req          = 1'b0;

        if (run) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (redir) begin
                        ifid_instr_next = NOP_WORD;
                        ifid_npc_next   = 32'd0;
                        ifid_valid_next = 1'b0;
                        if (imem_ready) begin
                            pc_next = redir_target;
                        end else begin
                            saved_target_next = redir_target;
                            state_next        = DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (advance) begin
                            ifid_instr_next = imem_rdata;
                            ifid_npc_next   = npc;
                            ifid_valid_next = 1'b1;
                            pc_next         = npc;
                        end else begin
                            hold_instr_next = imem_rdata;
                            hold_npc_next   = npc;
                            state_next      = HOLD;
                        end
                    end else if (IFIDWrite) begin
                        // ID consumed the previous word and nothing new arrived:
                        // hand it a bubble so the old word is not executed twice.
                        ifid_instr_next = NOP_WORD;
                        ifid_npc_next   = 32'd0;
                        ifid_valid_next = 1'b0;
                    end
                end

                HOLD: begin
                    if (redir) begin
                        ifid_instr_next = NOP_WORD;
                        ifid_npc_next   = 32'd0;
                        ifid_valid_next = 1'b0;
                        hold_instr_next = 32'd0;
                        hold_npc_next   = 32'd0;
                        pc_next         = redir_target;
                        state_next      = FETCH;
                    end else if (advance) begin
                        ifid_instr_next = hold_instr;
                        ifid_npc_next   = hold_npc;
                        ifid_valid_next = 1'b1;
                        pc_next         = hold_npc;
                        state_next      = FETCH;
                    end
                end

                DRAIN: begin
                    imem_req = 1'b1;
                    if (redir) begin
                        saved_target_next = redir_target;
                    end
                    if (redir || IFIDWrite) begin
                        ifid_instr_next = NOP_WORD;
                        ifid_npc_next   = 32'd0;
                        ifid_valid_next = 1'b0;
                    end
                    if (imem_ready) begin
                        pc_next    = redir ? redir_target : saved_target;
                        state_next = FETCH;
                    end
                end

                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // State, PC, buffers and IF/ID register with asynchronous reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            run             <= 1'b0;
            saved_target    <= 32'd0;
            hold_instr      <= 32'd0;
            hold_npc        <= 32'd0;
            instruction_out <= NOP_WORD;
            npc_out         <= 32'd0;
            ifid_valid      <= 1'b0;
        end else begin
            state           <= state_next;
            pc              <= pc_next;
            run             <= 1'b1;
            saved_target    <= saved_target_next;
            hold_instr      <= hold_instr_next;
            hold_npc        <= hold_npc_next;
            instruction_out <= ifid_instr_next;
            npc_out         <= ifid_npc_next;
            ifid_valid      <= ifid_valid_next;
        end
    end

endmodule

// File: tb/tb_i_fetch_stage.sv
// tb_i_fetch_stage: directed-vector bench for the IF stage.
// Instruction memory model: word at byte address A is 0x1000_0000 + A/4.
module tb_i_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        rst_wrap = 1'b0;
    logic        PCWrite = 1'b1;
    logic        IFIDWrite = 1'b1;
    logic        branchTaken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_ready = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] npc_out;
    logic        ifid_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_npc;
    logic        w_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    assign imem_rdata = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
    assign w_rdata    = 32'h1000_0000 + {2'b00, w_addr[31:2]};

    i_fetch_stage dut (
        .CLK(CLK), .RST(RST),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .branchTaken(branchTaken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction_out(instruction_out), .npc_out(npc_out),
        .ifid_valid(ifid_valid)
    );

    i_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(rst_wrap),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .branchTaken(branchTaken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(imem_ready), .imem_rdata(w_rdata),
        .instruction_out(w_instr), .npc_out(w_npc),
        .ifid_valid(w_valid)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
        vectors++;
        if (ifid_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", ifid_valid); end
        vectors++;
        if (instruction_out !== 32'h0 || npc_out !== 32'h0) begin
            miscompares++; $display("[TB] FAIL reset_ifid: got %h/%h want 00000000/00000000", instruction_out, npc_out);
        end
        RST = 1'b1;
        imem_ready = 1'b1;
        tick();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential_fetch();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (instruction_out !== 32'h1000_0000 + i || npc_out !== 32'(4 * (i + 1)) || ifid_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL seq_fetch_%0d: got %h/%h/%b want %h/%h/1", i, instruction_out, npc_out, ifid_valid,
                         32'h1000_0000 + i, 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall();
        PCWrite = 1'b0;
        IFIDWrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (imem_req !== 1'b0 || instruction_out !== 32'h1000_0004 || npc_out !== 32'd20) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got req=%b %h/%h want 0 10000004/00000014", i, imem_req, instruction_out, npc_out);
            end
        end
        PCWrite = 1'b1;
        IFIDWrite = 1'b1;
        tick();
        vectors++;
        if (instruction_out !== 32'h1000_0005 || npc_out !== 32'd24 || ifid_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL stall_release: got %h/%h/%b want 10000005/00000018/1", instruction_out, npc_out, ifid_valid);
        end
        tick();
        vectors++;
        if (instruction_out !== 32'h1000_0006 || npc_out !== 32'd28) begin
            miscompares++; $display("[TB] FAIL stall_resume: got %h/%h want 10000006/0000001c", instruction_out, npc_out);
        end
    endtask

    task automatic test_branch();
        branchTaken = 1'b1;
        branch_target = 32'h40;
        tick();
        branchTaken = 1'b0;
        vectors++;
        if (instruction_out !== 32'h0 || npc_out !== 32'h0 || ifid_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL branch_flush: got %h/%h/%b want 00000000/00000000/0", instruction_out, npc_out, ifid_valid);
        end
        vectors++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            miscompares++; $display("[TB] FAIL branch_addr: got req=%b addr=%h want 1/00000040", imem_req, imem_addr);
        end
        tick();
        vectors++;
        if (instruction_out !== 32'h1000_0010 || npc_out !== 32'h44 || ifid_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL branch_target_word: got %h/%h/%b want 10000010/00000044/1", instruction_out, npc_out, ifid_valid);
        end
    endtask

    task automatic test_jump_drain();
        imem_ready = 1'b0;
        jump = 1'b1;
        jump_target = 32'h80;
        tick();
        jump = 1'b0;
        vectors++;
        if (ifid_valid !== 1'b0 || instruction_out !== 32'h0) begin
            miscompares++; $display("[TB] FAIL jump_flush: got %h/%b want 00000000/0", instruction_out, ifid_valid);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin
                miscompares++; $display("[TB] FAIL drain_addr_%0d: got req=%b addr=%h want 1/00000044", i, imem_req, imem_addr);
            end
            if (i < 2) tick();
        end
        imem_ready = 1'b1;
        tick();
        vectors++;
        if (imem_addr !== 32'h80 || ifid_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL drain_done: got addr=%h valid=%b want 00000080/0", imem_addr, ifid_valid);
        end
        tick();
        vectors++;
        if (instruction_out !== 32'h1000_0020 || npc_out !== 32'h84 || ifid_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL jump_target_word: got %h/%h/%b want 10000020/00000084/1", instruction_out, npc_out, ifid_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        imem_ready = 1'b0;
        branchTaken = 1'b1;
        branch_target = 32'h100;
        tick();
        branchTaken = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin
            miscompares++; $display("[TB] FAIL pre_reset_drain: got req=%b addr=%h want 1/00000084", imem_req, imem_addr);
        end
        #2;
        RST = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL async_reset: got req=%b valid=%b addr=%h want 0/0/00000000", imem_req, ifid_valid, imem_addr);
        end
        #2;
        RST = 1'b1;
        imem_ready = 1'b1;
        tick();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL restart_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
        tick();
        vectors++;
        if (instruction_out !== 32'h1000_0000 || npc_out !== 32'h4 || ifid_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL restart_word: got %h/%h/%b want 10000000/00000004/1", instruction_out, npc_out, ifid_valid);
        end
    endtask

    task automatic test_pc_wrap();
        rst_wrap = 1'b1;
        tick();
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            miscompares++; $display("[TB] FAIL wrap_first_req: got req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        end
        tick();
        vectors++;
        if (w_instr !== 32'h4FFF_FFFF || w_npc !== 32'h0 || w_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL wrap_npc: got %h/%h/%b want 4fffffff/00000000/1", w_instr, w_npc, w_valid);
        end
        vectors++;
        if (w_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL wrap_next_addr: got %h want 00000000", w_addr);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_branch();
        test_jump_drain();
        test_reset_mid_drain();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
